// File: rtl/lcd_writer.sv
// HD44780-style 4-bit LCD writer: power-on wait, nibble init, fixed config bytes,
// then one byte per accepted start request, strobed out as two nibbles.
module lcd_writer #(
  parameter int T_POWERON  = 750000,
  parameter int T_INIT_NIB = 205000,
  parameter int T_SETUP    = 2,
  parameter int T_PULSE    = 12,
  parameter int T_HOLD     = 1,
  parameter int T_GAP      = 50,
  parameter int T_CMD      = 2000,
  parameter int T_LONG     = 82000
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  // state                       | meaning
  // POWERON                     | idle wait after reset
  // INIT_SETUP/PULSE/HOLD/WAIT  | init nibble strobe and its settle time
  // IDLE                        | ready for a write
  // HI_*, GAP, LO_*, WAIT       | byte path, shared by config bytes and user writes
  typedef enum logic [3:0] {
    POWERON, INIT_SETUP, INIT_PULSE, INIT_HOLD, INIT_WAIT, IDLE,
    HI_SETUP, HI_PULSE, HI_HOLD, GAP, LO_SETUP, LO_PULSE, LO_HOLD, WAIT
  } state_t;

  // Terminal count for an N-cycle wait; zero is stretched to one cycle.
  function automatic logic [19:0] term_of(input int n);
    return (n <= 1) ? 20'd0 : 20'(n - 1);
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  localparam logic [19:0] L_POWERON  = term_of(T_POWERON);
  localparam logic [19:0] L_INIT_NIB = term_of(T_INIT_NIB);
  localparam logic [19:0] L_SETUP    = term_of(T_SETUP);
  localparam logic [19:0] L_PULSE    = term_of(T_PULSE);
  localparam logic [19:0] L_HOLD     = term_of(T_HOLD);
  localparam logic [19:0] L_GAP      = term_of(T_GAP);
  localparam logic [19:0] L_CMD      = term_of(T_CMD);
  localparam logic [19:0] L_LONG     = term_of(T_LONG);

  state_t      state, state_n;
  logic [19:0] cnt, cnt_n, cur_lim;
  logic [1:0]  init_idx, init_idx_n, cfg_idx, cfg_idx_n;
  logic        cfg_mode, cfg_mode_n;
  logic        lat_rs, lat_rs_n;
  logic [7:0]  lat_data, lat_data_n;
  logic        e_n, rs_n;
  logic [3:0]  data_n;
  logic        term, is_long;

  assign is_long = !lat_rs && (lat_data == 8'h01 || lat_data == 8'h02);
  assign oReady  = (state == IDLE);
  assign oLCD_RW = 1'b0;

  always_comb begin
    cur_lim = 20'd0;
    case (state)
      POWERON:                          cur_lim = L_POWERON;
      INIT_SETUP, HI_SETUP, LO_SETUP:   cur_lim = L_SETUP;
      INIT_PULSE, HI_PULSE, LO_PULSE:   cur_lim = L_PULSE;
      INIT_HOLD, HI_HOLD, LO_HOLD:      cur_lim = L_HOLD;
      INIT_WAIT:                        cur_lim = (init_idx == 2'd0) ? L_INIT_NIB : L_CMD;
      GAP:                              cur_lim = L_GAP;
      WAIT:                             cur_lim = is_long ? L_LONG : L_CMD;
      default:                          cur_lim = 20'd0;
    endcase
  end

  assign term = (cnt == cur_lim);

  always_comb begin
    state_n    = state;
    cnt_n      = term ? 20'd0 : cnt + 20'd1;
    init_idx_n = init_idx;
    cfg_idx_n  = cfg_idx;
    cfg_mode_n = cfg_mode;
    lat_rs_n   = lat_rs;
    lat_data_n = lat_data;
    e_n        = oLCD_E;
    rs_n       = oLCD_RS;
    data_n     = oLCD_Data;
    case (state)
      POWERON: if (term) begin
        state_n = INIT_SETUP;
        rs_n    = 1'b0;
        data_n  = 4'h3;
      end
      INIT_SETUP: if (term) begin state_n = INIT_PULSE; e_n = 1'b1; end
      INIT_PULSE: if (term) begin state_n = INIT_HOLD;  e_n = 1'b0; end
      INIT_HOLD:  if (term) state_n = INIT_WAIT;
      INIT_WAIT: if (term) begin
        if (init_idx == 2'd3) begin
          state_n    = HI_SETUP;
          cfg_mode_n = 1'b1;
          cfg_idx_n  = 2'd0;
          lat_rs_n   = 1'b0;
          lat_data_n = cfg_byte(2'd0);
          data_n     = cfg_byte(2'd0)[7:4];
        end else begin
          state_n    = INIT_SETUP;
          init_idx_n = init_idx + 2'd1;
          data_n     = (init_idx == 2'd2) ? 4'h2 : 4'h3;
        end
      end
      IDLE: if (iStart) begin
        state_n    = HI_SETUP;
        lat_rs_n   = iRS;
        lat_data_n = iData;
        rs_n       = iRS;
        data_n     = iData[7:4];
      end
      HI_SETUP: if (term) begin state_n = HI_PULSE; e_n = 1'b1; end
      HI_PULSE: if (term) begin state_n = HI_HOLD;  e_n = 1'b0; end
      HI_HOLD:  if (term) state_n = GAP;
      GAP: if (term) begin
        state_n = LO_SETUP;
        data_n  = lat_data[3:0];
      end
      LO_SETUP: if (term) begin state_n = LO_PULSE; e_n = 1'b1; end
      LO_PULSE: if (term) begin state_n = LO_HOLD;  e_n = 1'b0; end
      LO_HOLD:  if (term) state_n = WAIT;
      WAIT: if (term) begin
        if (cfg_mode && cfg_idx != 2'd3) begin
          state_n    = HI_SETUP;
          cfg_idx_n  = cfg_idx + 2'd1;
          lat_data_n = cfg_byte(cfg_idx + 2'd1);
          data_n     = cfg_byte(cfg_idx + 2'd1)[7:4];
        end else begin
          state_n    = IDLE;
          cfg_mode_n = 1'b0;
        end
      end
      default: state_n = POWERON;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state     <= POWERON;
      cnt       <= 20'd0;
      init_idx  <= 2'd0;
      cfg_idx   <= 2'd0;
      cfg_mode  <= 1'b0;
      lat_rs    <= 1'b0;
      lat_data  <= 8'h00;
      oLCD_E    <= 1'b0;
      oLCD_RS   <= 1'b0;
      oLCD_Data <= 4'h0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      init_idx  <= init_idx_n;
      cfg_idx   <= cfg_idx_n;
      cfg_mode  <= cfg_mode_n;
      lat_rs    <= lat_rs_n;
      lat_data  <= lat_data_n;
      oLCD_E    <= e_n;
      oLCD_RS   <= rs_n;
      oLCD_Data <= data_n;
    end
  end

endmodule

// File: tb/tb_lcd_writer.sv
// Directed bench for lcd_writer with short timing parameters.
module tb_lcd_writer;

  logic       clk = 1'b0;
  logic       rst_n, start, rs;
  logic [7:0] data;
  logic       ready, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       rs;
    logic [3:0] data;
    int         width;
  } pulse_t;
  pulse_t pulses[$];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [3:0] hi;
    logic [3:0] lo;
    int         lat;
  } vec_t;
  vec_t vecs[7];

  logic [3:0] init_exp[12];

  lcd_writer #(
    .T_POWERON(8), .T_INIT_NIB(6), .T_SETUP(1), .T_PULSE(2),
    .T_HOLD(1), .T_GAP(3), .T_CMD(5), .T_LONG(9)
  ) dut (
    .iClock(clk), .iReset(rst_n), .iStart(start), .iRS(rs), .iData(data),
    .oReady(ready), .oLCD_E(lcd_e), .oLCD_RS(lcd_rs), .oLCD_RW(lcd_rw),
    .oLCD_Data(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle bus monitor: records E pulses and checks bus stability.
  logic       e_prev = 1'b0, rs_prev = 1'b0, rst_prev = 1'b0;
  logic [3:0] d_prev = 4'h0;
  logic       cur_rs;
  logic [3:0] cur_d;
  int         start_cyc;
  always @(posedge clk) begin
    #1;
    cyc++;
    chk("rw_low", {31'd0, lcd_rw}, 32'd0);
    if (rst_n && rst_prev && (lcd_e || e_prev))
      chk("bus_stable", {27'd0, lcd_rs, lcd_data}, {27'd0, rs_prev, d_prev});
    if (lcd_e && !e_prev) begin
      cur_rs = lcd_rs;
      cur_d = lcd_data;
      start_cyc = cyc;
    end
    if (!lcd_e && e_prev)
      pulses.push_back('{rs: cur_rs, data: cur_d, width: cyc - start_cyc});
    e_prev = lcd_e;
    rs_prev = lcd_rs;
    d_prev = lcd_data;
    rst_prev = rst_n;
  end

  task automatic wait_ready();
    int g = 0;
    while (!ready && g < 500) begin
      @(posedge clk); #2;
      g++;
    end
  endtask

  task automatic run_init();
    int rel, g;
    @(negedge clk);
    rst_n = 1'b1;
    pulses.delete();
    rel = cyc;
    g = 0;
    while (!lcd_e && g < 100) begin
      @(posedge clk); #2;
      g++;
    end
    chk("first_pulse_delay", cyc - rel, 9);
    wait_ready();
    chk("init_ready_delay", cyc - rel, 113);
    chk("init_pulse_count", pulses.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < pulses.size()) begin
        chk($sformatf("init_data[%0d]", i), {28'd0, pulses[i].data}, {28'd0, init_exp[i]});
        chk($sformatf("init_rs[%0d]", i), {31'd0, pulses[i].rs}, 32'd0);
        chk($sformatf("init_width[%0d]", i), pulses[i].width, 2);
      end
    end
  endtask

  task automatic do_write(input vec_t v, input int idx);
    int acc;
    pulses.delete();
    @(negedge clk);
    start = 1'b1; rs = v.rs; data = v.data;
    @(negedge clk);
    start = 1'b0; rs = ~v.rs; data = ~v.data;
    acc = cyc;
    chk($sformatf("v%0d_ready_low", idx), {31'd0, ready}, 32'd0);
    chk($sformatf("v%0d_setup_rs", idx), {31'd0, lcd_rs}, {31'd0, v.rs});
    chk($sformatf("v%0d_setup_data", idx), {28'd0, lcd_data}, {28'd0, v.hi});
    chk($sformatf("v%0d_setup_e", idx), {31'd0, lcd_e}, 32'd0);
    wait_ready();
    chk($sformatf("v%0d_latency", idx), cyc - acc, v.lat);
    chk($sformatf("v%0d_pulses", idx), pulses.size(), 2);
    if (pulses.size() >= 2) begin
      chk($sformatf("v%0d_hi", idx), {28'd0, pulses[0].data}, {28'd0, v.hi});
      chk($sformatf("v%0d_lo", idx), {28'd0, pulses[1].data}, {28'd0, v.lo});
      chk($sformatf("v%0d_rs_hi", idx), {31'd0, pulses[0].rs}, {31'd0, v.rs});
      chk($sformatf("v%0d_rs_lo", idx), {31'd0, pulses[1].rs}, {31'd0, v.rs});
      chk($sformatf("v%0d_width_hi", idx), pulses[0].width, 2);
      chk($sformatf("v%0d_width_lo", idx), pulses[1].width, 2);
    end
  endtask

  initial begin
    int acc, acc2, g;
    init_exp = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    vecs[0] = '{rs: 1'b1, data: 8'h48, hi: 4'h4, lo: 4'h8, lat: 16};
    vecs[1] = '{rs: 1'b0, data: 8'h01, hi: 4'h0, lo: 4'h1, lat: 20};
    vecs[2] = '{rs: 1'b0, data: 8'h80, hi: 4'h8, lo: 4'h0, lat: 16};
    vecs[3] = '{rs: 1'b0, data: 8'h02, hi: 4'h0, lo: 4'h2, lat: 20};
    vecs[4] = '{rs: 1'b1, data: 8'h01, hi: 4'h0, lo: 4'h1, lat: 16};
    vecs[5] = '{rs: 1'b0, data: 8'h03, hi: 4'h0, lo: 4'h3, lat: 16};
    vecs[6] = '{rs: 1'b1, data: 8'hA5, hi: 4'hA, lo: 4'h5, lat: 16};

    rst_n = 1'b0; start = 1'b0; rs = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_data", {28'd0, lcd_data}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);

    run_init();

    for (int i = 0; i < 7; i++) do_write(vecs[i], i);

    // Held start: exactly one new write per return to IDLE.
    pulses.delete();
    @(negedge clk);
    start = 1'b1; rs = 1'b0; data = 8'h80;
    @(negedge clk);
    acc = cyc;
    wait_ready();
    chk("held_first_latency", cyc - acc, 16);
    @(posedge clk); #2;
    chk("held_reaccept", {31'd0, ready}, 32'd0);
    acc2 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_ready();
    chk("held_second_latency", cyc - acc2, 16);
    chk("held_pulses", pulses.size(), 4);

    // Start on the last WAIT cycle is ignored.
    pulses.delete();
    @(negedge clk);
    start = 1'b1; rs = 1'b0; data = 8'h80;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    g = 0;
    while (cyc < acc + 15 && g < 50) begin
      @(posedge clk); #2;
      g++;
    end
    @(negedge clk);
    chk("wait_end_not_ready", {31'd0, ready}, 32'd0);
    start = 1'b1; data = 8'h33;
    @(negedge clk);
    start = 1'b0;
    chk("wait_end_ready", {31'd0, ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("wait_end_pulses", pulses.size(), 2);
    chk("wait_end_still_ready", {31'd0, ready}, 32'd1);

    // Start while busy is ignored and does not corrupt the byte in flight.
    pulses.delete();
    @(negedge clk);
    start = 1'b1; rs = 1'b1; data = 8'h41;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    repeat (2) @(negedge clk);
    start = 1'b1; rs = 1'b0; data = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_ready();
    chk("busy_latency", cyc - acc, 16);
    repeat (20) @(negedge clk);
    chk("busy_pulses", pulses.size(), 2);
    if (pulses.size() >= 2) begin
      chk("busy_hi", {28'd0, pulses[0].data}, 32'h4);
      chk("busy_lo", {28'd0, pulses[1].data}, 32'h1);
      chk("busy_rs", {31'd0, pulses[1].rs}, 32'd1);
    end
    chk("busy_ready", {31'd0, ready}, 32'd1);

    // Reset in the middle of the high-nibble pulse.
    @(negedge clk);
    start = 1'b1; rs = 1'b1; data = 8'h48;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!lcd_e && g < 20) begin
      @(posedge clk); #2;
      g++;
    end
    chk("pulse_before_reset", {31'd0, lcd_e}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_e", {31'd0, lcd_e}, 32'd0);
    chk("reset_rs", {31'd0, lcd_rs}, 32'd0);
    chk("reset_data", {28'd0, lcd_data}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    repeat (3) @(negedge clk);
    run_init();
    do_write(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
